// File: rtl/ppu_pkg.sv
// Shared types and constants for PPU sprite evaluation: FSM states, OAM byte
// offsets within a 4-byte sprite entry, and sprite attribute bit positions.
package ppu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_EVAL  = 2'd2,
        ST_FETCH = 2'd3
    } eval_state_t;

    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_TILE = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_X    = 2'd3;

    localparam int ATTR_PAL_LSB = 0;
    localparam int ATTR_PAL_MSB = 1;
    localparam int ATTR_PRIO    = 5;
    localparam int ATTR_FLIP_H  = 6;
    localparam int ATTR_FLIP_V  = 7;

    localparam logic [7:0] SEC_FILL = 8'hFF;

endpackage

// File: rtl/oam_ram.sv
// Primary OAM: a CPU read/write port and a read-only evaluation port, both
// with synchronous (one-cycle) read.
module oam_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2**AW];

    // The CPU is the only writer; a read colliding with a write returns the old byte.
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[cpu_addr] <= cpu_wdata;
        end
        cpu_rdata <= mem[cpu_addr];
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sprite_eval.sv
// Scanline sprite evaluation: clears secondary OAM, scans primary OAM for
// sprites covering the line, then streams them out. Macro SPRITE_OVF_BUG_EN
// enables the 2C02 diagonal overflow scan.
module sprite_eval
    import ppu_pkg::*;
#(
    parameter int N_OAM  = 64,
    parameter int N_LINE = 8,
    parameter int Y_W    = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic [Y_W-1:0]           line,
    input  logic                     tall,
    input  logic [$clog2(N_OAM)+1:0] cpu_addr,
    input  logic                     cpu_we,
    input  logic [7:0]               cpu_wdata,
    output logic [7:0]               cpu_rdata,
    output logic                     sp_valid,
    input  logic                     sp_ready,
    output logic [3:0]               sp_row,
    output logic [7:0]               sp_tile,
    output logic [7:0]               sp_attr,
    output logic [7:0]               sp_x,
    output logic                     sp_is0,
    output logic                     overflow,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(N_OAM) + 2;
    localparam int EW = $clog2(N_OAM);
    localparam int LW = (N_LINE > 1) ? $clog2(N_LINE) : 1;
    localparam int SW = LW + 1;
    localparam int CW = LW + 2;
    localparam logic [CW-1:0]  CLR_LAST   = CW'(4 * N_LINE - 1);
    localparam logic [EW-1:0]  ENTRY_LAST = EW'(N_OAM - 1);
    localparam logic [Y_W:0]   H8         = (Y_W+1)'(8);
    localparam logic [Y_W:0]   H16        = (Y_W+1)'(16);

    eval_state_t   state, nstate;
    logic [AW-1:0] idx, idx_nxt;
    logic [EW-1:0] entry;
    logic [1:0]    boff, nboff;
    logic [SW-1:0] slot_cnt;
    logic [LW-1:0] f_idx;
    logic [CW-1:0] clr_cnt;
    logic [Y_W-1:0] line_r;
    logic          tall_r, ovf_r;
    logic [7:0]    sec [N_LINE][4];
    logic [N_LINE-1:0] sec_is0;
    logic [7:0]    q;
    logic [Y_W:0]  diff;
    logic          in_range, full, wr_slot, slot_inc, adv, ovf_set;
    logic          eval_done, found, last_slot;

    // The eval port is addressed with next-cycle idx so q always holds primary[idx].
    oam_ram #(.AW(AW)) u_oam (
        .clk       (clk),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .rd_en     (ena),
        .rd_addr   (idx_nxt),
        .rd_data   (q)
    );

    always_comb begin
        entry    = idx[AW-1:2];
        boff     = idx[1:0];
        diff     = {1'b0, line_r} - (Y_W+1)'(q);
        in_range = !diff[Y_W] && (diff < (tall_r ? H16 : H8));
        full     = (slot_cnt == SW'(N_LINE));
        wr_slot  = 1'b0;
        slot_inc = 1'b0;
        adv      = 1'b0;
        ovf_set  = 1'b0;
        nboff    = boff;
        if (state == ST_EVAL) begin
            if (!full) begin
                if (boff == OFS_Y) begin
                    if (in_range) begin
                        wr_slot = 1'b1;
                        nboff   = OFS_TILE;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    wr_slot = 1'b1;
                    nboff   = boff + 2'd1;
                    if (boff == OFS_X) begin
                        adv      = 1'b1;
                        slot_inc = 1'b1;
                    end
                end
            end else begin
                adv     = 1'b1;
                ovf_set = in_range;
`ifdef SPRITE_OVF_BUG_EN
                if (!in_range) begin
                    nboff = boff + 2'd1;
                end
`endif
            end
        end
        eval_done = adv && (entry == ENTRY_LAST);
        found     = (slot_cnt != '0) || slot_inc;
        last_slot = ({1'b0, f_idx} == slot_cnt - 1'b1);
        if (start) begin
            idx_nxt = '0;
        end else if (state == ST_EVAL) begin
            idx_nxt = {adv ? entry + 1'b1 : entry, nboff};
        end else if (state == ST_CLEAR) begin
            idx_nxt = '0;
        end else begin
            idx_nxt = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        if (start) begin
            nstate = ST_CLEAR;
        end else begin
            case (state)
                ST_CLEAR: if (clr_cnt == CLR_LAST) nstate = ST_EVAL;
                ST_EVAL:  if (eval_done) nstate = found ? ST_FETCH : ST_IDLE;
                ST_FETCH: if (sp_ready && last_slot) nstate = ST_IDLE;
                default:  nstate = ST_IDLE;
            endcase
        end
    end

    // sp_valid/sp_ready: a transfer happens on a rising edge where sp_valid,
    // sp_ready and ena are all high; payload holds until then. start wins.
    always_comb begin
        sp_valid  = (state == ST_FETCH);
        busy      = (state != ST_IDLE);
        dbg_state = state;
        overflow  = ovf_r;
        sp_row    = line_r[3:0] - sec[f_idx][OFS_Y][3:0];
        sp_tile   = sec[f_idx][OFS_TILE];
        sp_attr   = sec[f_idx][OFS_ATTR];
        sp_x      = sec[f_idx][OFS_X];
        sp_is0    = sec_is0[f_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            slot_cnt <= '0;
            f_idx    <= '0;
            clr_cnt  <= '0;
            line_r   <= '0;
            tall_r   <= 1'b0;
            ovf_r    <= 1'b0;
            sec_is0  <= '0;
            for (int i = 0; i < N_LINE; i++) begin
                for (int j = 0; j < 4; j++) begin
                    sec[i][j] <= 8'h00;
                end
            end
        end else if (ena) begin
            idx <= idx_nxt;
            if (start) begin
                slot_cnt <= '0;
                f_idx    <= '0;
                clr_cnt  <= '0;
                line_r   <= line;
                tall_r   <= tall;
                ovf_r    <= 1'b0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        sec[clr_cnt[CW-1:2]][clr_cnt[1:0]] <= SEC_FILL;
                        sec_is0[clr_cnt[CW-1:2]]            <= 1'b0;
                        clr_cnt                             <= clr_cnt + 1'b1;
                    end
                    ST_EVAL: begin
                        if (wr_slot) begin
                            sec[slot_cnt[LW-1:0]][boff] <= q;
                        end
                        if (wr_slot && (boff == OFS_Y)) begin
                            sec_is0[slot_cnt[LW-1:0]] <= (entry == '0);
                        end
                        if (slot_inc) begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                        if (ovf_set) begin
                            ovf_r <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (sp_ready && !last_slot) begin
                            f_idx <= f_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_eval.sv
// Bench for sprite_eval: randomized OAM contents checked against a per-entry
// scan model of the scanline rules, plus directed corner scenarios.
module tb_sprite_eval;

    localparam int N_OAM  = 64;
    localparam int N_LINE = 8;
    localparam int Y_W    = 9;
    localparam int AW     = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           ena = 1'b1;
    logic           start = 1'b0;
    logic [Y_W-1:0] line = '0;
    logic           tall = 1'b0;
    logic [AW-1:0]  cpu_addr = '0;
    logic           cpu_we = 1'b0;
    logic [7:0]     cpu_wdata = 8'h00;
    logic           sp_ready = 1'b0;
    logic [7:0]     cpu_rdata;
    logic           sp_valid;
    logic [3:0]     sp_row;
    logic [7:0]     sp_tile, sp_attr, sp_x;
    logic           sp_is0, overflow, busy;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  oam_m [N_OAM*4];
    logic [28:0] exp_q [$];
    logic [28:0] got_q [$];
    logic        exp_ovf;
    int          exp_busy;
    int          busy_cycles;
    bit          timed_out;

    sprite_eval #(.N_OAM(N_OAM), .N_LINE(N_LINE), .Y_W(Y_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .line(line), .tall(tall),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_row(sp_row), .sp_tile(sp_tile),
        .sp_attr(sp_attr), .sp_x(sp_x), .sp_is0(sp_is0), .overflow(overflow),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic fill_oam(input logic [7:0] v);
        for (int i = 0; i < N_OAM*4; i++) oam_m[i] = v;
    endtask

    task automatic load_oam();
        for (int i = 0; i < N_OAM*4; i++) begin
            @(negedge clk);
            cpu_addr = AW'(i); cpu_wdata = oam_m[i]; cpu_we = 1'b1;
        end
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic start_line(input int ln, input bit tl);
        got_q.delete();
        busy_cycles = 0;
        @(negedge clk);
        line = Y_W'(ln); tall = tl; start = 1'b1; ena = 1'b1; sp_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int stall_pct, input bit rand_ena);
        bit done = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (!busy) begin
                done = 1;
            end else begin
                busy_cycles++;
                sp_ready = ($urandom_range(0, 99) >= stall_pct);
                ena = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (sp_valid && sp_ready && ena)
                    got_q.push_back({sp_is0, sp_row, sp_tile, sp_attr, sp_x});
                @(negedge clk);
            end
        end
        timed_out = !done;
        ena = 1'b1; sp_ready = 1'b0;
    endtask

    task automatic run_line(input int ln, input bit tl, input int stall_pct, input bit rand_ena);
        start_line(ln, tl);
        collect(stall_pct, rand_ena);
    endtask

    // ---------------- reference model ----------------
    // Entries in OAM order; the first N_LINE covering the line are emitted,
    // any further covering entry flags overflow.
    task automatic model(input int ln, input bit tl);
        int hits = 0;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int e = 0; e < N_OAM; e++) begin
            int d = ln - int'(oam_m[e*4]);
            if (d >= 0 && d < (tl ? 16 : 8)) begin
                if (hits < N_LINE)
                    exp_q.push_back({(e == 0), 4'(d), oam_m[e*4+1], oam_m[e*4+2], oam_m[e*4+3]});
                else
                    exp_ovf = 1'b1;
                hits++;
            end
        end
        exp_busy = 4*N_LINE + N_OAM + 4*exp_q.size();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++;
        if ({sp_row, sp_tile, sp_attr, sp_x, sp_is0} !== 29'd0) begin
            errors++; $display("FAIL reset_payload got %h exp 0", {sp_row, sp_tile, sp_attr, sp_x, sp_is0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got busy %b exp 0", busy); end
    endtask

    task automatic test_cpu_port();
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] a  = AW'($urandom_range(0, N_OAM*4-1));
            logic [7:0]    d1 = 8'($urandom_range(0, 255));
            logic [7:0]    d2 = 8'($urandom_range(0, 255));
            @(negedge clk); cpu_addr = a; cpu_wdata = d1; cpu_we = 1'b1;
            @(negedge clk); cpu_wdata = d2;
            @(negedge clk); cpu_we = 1'b0;
            checks++; if (cpu_rdata !== d1) begin errors++; $display("FAIL cpu_collide got %h exp %h", cpu_rdata, d1); end
            @(negedge clk);
            checks++; if (cpu_rdata !== d2) begin errors++; $display("FAIL cpu_read got %h exp %h", cpu_rdata, d2); end
        end
    endtask

    task automatic compare_run(input string nm, input bit check_busy);
        checks++; if (timed_out) begin errors++; $display("FAIL %s_timeout busy still %b", nm, busy); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_count got %0d exp %0d", nm, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL %s_sprite%0d got %h exp %h", nm, i, got_q[i], exp_q[i]);
            end
        end
`ifndef SPRITE_OVF_BUG_EN
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL %s_ovf got %b exp %b", nm, overflow, exp_ovf); end
`endif
        if (check_busy) begin
            checks++;
            if (busy_cycles != exp_busy) begin
                errors++; $display("FAIL %s_busy_cycles got %0d exp %0d", nm, busy_cycles, exp_busy);
            end
        end
    endtask

    task automatic test_sprite0();
        fill_oam(8'hF0);
        oam_m[0] = 8'd10; oam_m[1] = 8'h5A; oam_m[2] = 8'h23; oam_m[3] = 8'h77;
        load_oam();
        model(12, 1'b0);
        run_line(12, 1'b0, 0, 1'b0);
        compare_run("sprite0", 1'b1);
    endtask

    task automatic test_nine();
        fill_oam(8'hF0);
        for (int e = 0; e < 9; e++) begin
            oam_m[e*4] = 8'd20; oam_m[e*4+1] = 8'(e); oam_m[e*4+2] = 8'($urandom_range(0, 255));
            oam_m[e*4+3] = 8'($urandom_range(0, 255));
        end
        load_oam();
        model(20, 1'b0);
        run_line(20, 1'b0, 0, 1'b0);
        compare_run("nine", 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL nine_ovf got %b exp 1", overflow); end
    endtask

    task automatic test_tall();
        fill_oam(8'hF0);
        oam_m[20] = 8'd10; oam_m[21] = 8'h31; oam_m[22] = 8'h80; oam_m[23] = 8'h44;
        load_oam();
        model(25, 1'b1);
        run_line(25, 1'b1, 0, 1'b0);
        compare_run("tall16", 1'b1);
        model(25, 1'b0);
        run_line(25, 1'b0, 0, 1'b0);
        compare_run("tall8", 1'b1);
    endtask

    task automatic test_ovf_diag();
        fill_oam(8'hF0);
        for (int e = 0; e < 8; e++) begin
            oam_m[e*4] = 8'd40; oam_m[e*4+1] = 8'(8'h10 + e);
        end
        oam_m[33] = 8'd40;
        oam_m[37] = 8'd40;
        load_oam();
        model(40, 1'b0);
`ifdef SPRITE_OVF_BUG_EN
        exp_ovf = 1'b1;
`endif
        run_line(40, 1'b0, 0, 1'b0);
        compare_run("diag", 1'b1);
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL diag_ovf got %b exp %b", overflow, exp_ovf); end
    endtask

    task automatic test_backpressure();
        logic [28:0] hold;
        bit seen = 0;
        fill_oam(8'hF0);
        oam_m[12] = 8'd95; oam_m[40] = 8'd99; oam_m[44] = 8'd100; oam_m[160] = 8'd93;
        for (int i = 0; i < N_OAM*4; i++) if (i % 4 != 0) oam_m[i] = 8'($urandom_range(0, 255));
        load_oam();
        model(100, 1'b0);
        start_line(100, 1'b0);
        for (int cyc = 0; cyc < 500 && !seen; cyc++) begin
            if (sp_valid) seen = 1; else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_wait got valid %b exp 1", sp_valid); end
        hold = {sp_is0, sp_row, sp_tile, sp_attr, sp_x};
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (!sp_valid || {sp_is0, sp_row, sp_tile, sp_attr, sp_x} !== hold) begin
                errors++; $display("FAIL bp_stable got %b/%h exp 1/%h", sp_valid,
                                   {sp_is0, sp_row, sp_tile, sp_attr, sp_x}, hold);
            end
        end
        collect(0, 1'b0);
        compare_run("bp", 1'b0);
    endtask

    task automatic test_abort();
        model(100, 1'b0);
        start_line(30, 1'b0);
        repeat (20) @(negedge clk);
        start_line(100, 1'b0);
        collect(0, 1'b0);
        compare_run("abort", 1'b1);
    endtask

    task automatic test_reset_mid();
        start_line(100, 1'b0);
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got busy %b exp 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", sp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        model(100, 1'b0);
        run_line(100, 1'b0, 0, 1'b0);
        compare_run("midrst", 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int ln = $urandom_range(0, 270);
            bit tl = 1'($urandom_range(0, 1));
            for (int i = 0; i < N_OAM*4; i++) oam_m[i] = 8'($urandom_range(0, 255));
            for (int e = 0; e < N_OAM; e++)
                if ($urandom_range(0, 3) == 0) oam_m[e*4] = 8'(ln - $urandom_range(0, 17));
            load_oam();
            model(ln, tl);
            run_line(ln, tl, 30, 1'b1);
            compare_run($sformatf("rand%0d", it), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_port();
        test_sprite0();
        test_nine();
        test_tall();
        test_ovf_diag();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_eval.md
SPRITE_EVAL -- requirements
Module: sprite_eval

Interface
REQ-001 Parameter N_OAM, default 64, sprites held in primary OAM (power of two, 8..256).
REQ-002 Parameter N_LINE, default 8, secondary OAM slots per scanline (power of two, 1..32).
REQ-003 Parameter Y_W, default 9, scanline counter width.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ena  in  1  advance enable; when 0 all state, counters and flags hold.
REQ-007 start  in  1  one-cycle pulse beginning evaluation for scanline line.
REQ-008 line  in  Y_W  scanline being evaluated, sampled on start.
REQ-009 tall  in  1  0 = 8-row sprites, 1 = 16-row sprites, sampled on start.
REQ-010 cpu_addr  in  log2(N_OAM)+2  CPU OAM byte address.
REQ-011 cpu_we / cpu_wdata  in  1 / 8  CPU OAM write strobe and data.
REQ-012 cpu_rdata  out  8  CPU OAM read data, one-cycle latency.
REQ-013 sp_valid / sp_ready  out / in  1 / 1  output sprite handshake.
REQ-014 sp_row, sp_tile, sp_attr, sp_x  out  4, 8, 8, 8  row within sprite, tile, attribute, X.
REQ-015 sp_is0  out  1  emitted sprite is OAM entry 0.
REQ-016 overflow  out  1  more than N_LINE sprites in range on this line.
REQ-017 busy  out  1  high from start until last sprite accepted or none found.

Function
REQ-018 States IDLE, CLEAR, EVAL, FETCH; start in any state shall abort and enter CLEAR next cycle.
REQ-019 CLEAR shall write 8'hFF to all 4*N_LINE secondary bytes, one per cycle, then enter EVAL.
REQ-020 EVAL shall read one primary byte per cycle; in-range test: 0 <= line - Y < (tall ? 16 : 8), computed in Y_W+1 bits, no wrap acceptance.
REQ-021 Out-of-range sprite shall cost 1 cycle; in-range sprite shall cost 4 cycles, copying Y, tile, attr, X to the next slot.
REQ-022 After N_LINE slots fill, further in-range sprites shall set overflow and are not copied; scanning continues to entry N_OAM-1.
REQ-023 EVAL shall end after entry N_OAM-1 (index wraps to 0 without re-scan); zero sprites found shall go straight to IDLE.
REQ-024 FETCH shall present slots in OAM order; sp_valid with payload held stable until sp_ready; one transfer per cycle max.
REQ-025 sp_row = line - Y (low 4 bits); sp_is0 high only for a slot copied from entry 0.
REQ-026 overflow shall clear on start and stay set until next start.
REQ-027 CPU write in the same cycle as an EVAL read of that byte: EVAL sees old data, write completes.

Reset
REQ-028 rst_n low: state IDLE, all counters 0, sp_valid 0, overflow 0, busy 0, sp_* payload 0; primary OAM contents undefined.

Configuration
REQ-029 Macro SPRITE_OVF_BUG_EN defined: after slots fill, byte index shall advance diagonally (entry+1 and byte+1 mod 4) on each miss, reproducing the 2C02 false overflow/miss; undefined: correct per-entry Y check (REQ-022).

Structure
REQ-030 ppu_pkg shall hold the state enum, OAM byte offsets (Y=0, TILE=1, ATTR=2, X=3) and attribute bit positions.
REQ-031 Primary OAM shall be a sub-module oam_ram: dual-port, synchronous read, CPU port priority on write.

Verification
REQ-032 Sprite 0 Y=10, line=12, tall=0 -> one transfer, sp_row=2, sp_is0=1, overflow=0.
REQ-033 Nine sprites Y=20, line=20, N_LINE=8 -> eight transfers entries 0..7, overflow=1.
REQ-034 Y=10, line=25, tall=1 -> sp_row=15 emitted; tall=0 -> nothing, busy drops after EVAL.
REQ-035 sp_ready held low 5 cycles -> payload stable, no transfer lost, order preserved.
REQ-036 rst_n pulsed low mid-EVAL -> IDLE same cycle, sp_valid=0; new start completes normally.
REQ-037 SPRITE_OVF_BUG_EN, eight in-range then entry 8 out-of-range with tile byte in range -> overflow=1.
